// File: rtl/exemem_pkg.sv
// Shared definitions for the exemem reader/writer blocks: default widths and
// the FSM state encoding used by the RTL and the benches.
package exemem_pkg;

    localparam int EXEMEM_DATA_WIDTH = 16;
    localparam int EXEMEM_ADDR_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        WAIT = 3'd2,
        OUT  = 3'd3,
        DONE = 3'd4
    } state_e;

endpackage

// File: rtl/exemem_reader.sv
// Block reader for the dual-port exemem RAM: fetches consecutive word pairs from
// both ports, streams them on a valid/ready interface and keeps per-port checksums.
module exemem_reader
    import exemem_pkg::*;
#(
    parameter int DATA_WIDTH = EXEMEM_DATA_WIDTH,
    parameter int ADDR_WIDTH = EXEMEM_ADDR_WIDTH,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr1,
    input  logic [ADDR_WIDTH-1:0] base_addr2,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic [ADDR_WIDTH-1:0] addr1,
    output logic [ADDR_WIDTH-1:0] addr2,
    output logic                  we1,
    output logic                  we2,
    input  logic [DATA_WIDTH-1:0] memOut1,
    input  logic [DATA_WIDTH-1:0] memOut2,
    output logic [DATA_WIDTH-1:0] dataOut1,
    output logic [DATA_WIDTH-1:0] dataOut2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] sum1,
    output logic [DATA_WIDTH-1:0] sum2,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]  CNT_ONE  = LEN_WIDTH'(1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr1_q, addr1_d;
    logic [ADDR_WIDTH-1:0] addr2_q, addr2_d;
    logic [DATA_WIDTH-1:0] data1_q, data1_d;
    logic [DATA_WIDTH-1:0] data2_q, data2_d;
    logic [DATA_WIDTH-1:0] sum1_q, sum1_d;
    logic [DATA_WIDTH-1:0] sum2_q, sum2_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic                  out_valid_q, out_valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [LEN_WIDTH-1:0]  cnt_next;

    assign cnt_next = cnt_q + CNT_ONE;

    always_comb begin
        state_d = state_q;
        addr1_d = addr1_q;
        addr2_d = addr2_q;
        data1_d = data1_q;
        data2_d = data2_q;
        sum1_d  = sum1_q;
        sum2_d  = sum2_q;
        cnt_d   = cnt_q;
        len_d   = len_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr1_d = base_addr1;
                    addr2_d = base_addr2;
                    len_d   = len;
                    sum1_d  = '0;
                    sum2_d  = '0;
                    cnt_d   = '0;
                    state_d = (len == '0) ? DONE : ADDR;
                end
            end
            ADDR: state_d = WAIT;
            WAIT: begin
                data1_d = memOut1;
                data2_d = memOut2;
                sum1_d  = sum1_q + memOut1;
                sum2_d  = sum2_q + memOut2;
                state_d = OUT;
            end
            OUT: begin
                // out_valid is high for the whole OUT state, so ready alone completes the handshake
                if (out_ready) begin
                    cnt_d   = cnt_next;
                    addr1_d = addr1_q + ADDR_ONE;
                    addr2_d = addr2_q + ADDR_ONE;
                    state_d = (cnt_next == len_q) ? DONE : ADDR;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        out_valid_d = (state_d == OUT);
        busy_d      = (state_d == ADDR) || (state_d == WAIT) || (state_d == OUT);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            addr1_q     <= '0;
            addr2_q     <= '0;
            data1_q     <= '0;
            data2_q     <= '0;
            sum1_q      <= '0;
            sum2_q      <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr1_q     <= addr1_d;
            addr2_q     <= addr2_d;
            data1_q     <= data1_d;
            data2_q     <= data2_d;
            sum1_q      <= sum1_d;
            sum2_q      <= sum2_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign addr1     = addr1_q;
    assign addr2     = addr2_q;
    assign we1       = 1'b0;
    assign we2       = 1'b0;
    assign dataOut1  = data1_q;
    assign dataOut2  = data2_q;
    assign sum1      = sum1_q;
    assign sum2      = sum2_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_exemem_reader.sv
// Directed bench for exemem_reader with a behavioural dual-port RAM
// (1-cycle synchronous read) and a posedge handshake/event monitor.
module tb_exemem_reader;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int LW = AW + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr1, base_addr2;
    logic [LW-1:0] len;
    logic [AW-1:0] addr1, addr2;
    logic          we1, we2;
    logic [DW-1:0] memOut1, memOut2;
    logic [DW-1:0] dataOut1, dataOut2;
    logic          out_valid, out_ready;
    logic [DW-1:0] sum1, sum2;
    logic          busy, done;

    logic [DW-1:0] mem [256];

    int nVectors = 0;
    int nMiscompares = 0;

    int hsCount = 0, doneCount = 0, busyCount = 0, validCount = 0, weCount = 0;
    logic [AW-1:0] logA1 [64];
    logic [AW-1:0] logA2 [64];
    logic [DW-1:0] logD1 [64];
    logic [DW-1:0] logD2 [64];

    exemem_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .base_addr1(base_addr1), .base_addr2(base_addr2), .len(len),
        .addr1(addr1), .addr2(addr2), .we1(we1), .we2(we2),
        .memOut1(memOut1), .memOut2(memOut2),
        .dataOut1(dataOut1), .dataOut2(dataOut2),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum1(sum1), .sum2(sum2), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        memOut1 <= mem[addr1];
        memOut2 <= mem[addr2];
    end

    always @(posedge clk) begin
        if (out_valid && out_ready && hsCount < 64) begin
            logA1[hsCount] = addr1;
            logA2[hsCount] = addr2;
            logD1[hsCount] = dataOut1;
            logD2[hsCount] = dataOut2;
        end
        if (out_valid && out_ready) hsCount++;
        if (done) doneCount++;
        if (busy) busyCount++;
        if (out_valid) validCount++;
        if (we1 || we2) weCount++;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nVectors++;
        assert (observed === expected) else begin
            nMiscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [AW-1:0] b1, input logic [AW-1:0] b2, input logic [LW-1:0] l);
        start      = 1'b1;
        base_addr1 = b1;
        base_addr2 = b2;
        len        = l;
        tick();
        start      = 1'b0;
    endtask

    task automatic waitValid(input string tag);
        for (int i = 0; i < 12; i++) begin
            if (out_valid) break;
            tick();
        end
        checkOutput(tag, 32'(out_valid), 32'd1);
    endtask

    task automatic waitDone(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (done) break;
            tick();
        end
        checkOutput(tag, 32'(done), 32'd1);
    endtask

    initial begin
        int hsBase, doneBase, busyBase, validBase;
        logic [DW-1:0] e1 [4];
        logic [DW-1:0] e2 [4];

        for (int i = 0; i < 256; i++) mem[i] = '0;
        reset = 1'b0; start = 1'b0; out_ready = 1'b1;
        base_addr1 = '0; base_addr2 = '0; len = '0;
        @(negedge clk);
        tick();
        checkOutput("rst addr1", 32'(addr1), 32'd0);
        checkOutput("rst busy", 32'(busy), 32'd0);
        checkOutput("rst valid", 32'(out_valid), 32'd0);
        checkOutput("rst done", 32'(done), 32'd0);
        checkOutput("rst sum1", 32'(sum1), 32'd0);
        reset = 1'b1;
        tick();

        // Single pair, exact latency
        mem[1] = 16'd69; mem[3] = 16'd21;
        hsBase = hsCount;
        applyStimulus(8'd1, 8'd3, 9'd1);
        checkOutput("t1 c1 busy", 32'(busy), 32'd1);
        checkOutput("t1 c1 addr1", 32'(addr1), 32'd1);
        checkOutput("t1 c1 addr2", 32'(addr2), 32'd3);
        tick();
        checkOutput("t1 c2 valid", 32'(out_valid), 32'd0);
        tick();
        checkOutput("t1 c3 valid", 32'(out_valid), 32'd1);
        checkOutput("t1 dataOut1", 32'(dataOut1), 32'h45);
        checkOutput("t1 dataOut2", 32'(dataOut2), 32'h15);
        tick();
        checkOutput("t1 done", 32'(done), 32'd1);
        checkOutput("t1 busy", 32'(busy), 32'd0);
        checkOutput("t1 sum1", 32'(sum1), 32'd69);
        checkOutput("t1 sum2", 32'(sum2), 32'd21);
        tick();
        checkOutput("t1 done low", 32'(done), 32'd0);
        checkOutput("t1 handshakes", 32'(hsCount - hsBase), 32'd1);

        // Three pairs with a 4-cycle stall on the second
        mem[10] = 16'd1;  mem[11] = 16'd2;  mem[12] = 16'd3;
        mem[20] = 16'd10; mem[21] = 16'd20; mem[22] = 16'd30;
        hsBase = hsCount;
        applyStimulus(8'd10, 8'd20, 9'd3);
        waitValid("t2 p1 valid");
        checkOutput("t2 p1 d1", 32'(dataOut1), 32'd1);
        checkOutput("t2 p1 d2", 32'(dataOut2), 32'd10);
        tick();
        out_ready = 1'b0;
        waitValid("t2 p2 valid");
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("t2 stall valid", 32'(out_valid), 32'd1);
            checkOutput("t2 stall d1", 32'(dataOut1), 32'd2);
            checkOutput("t2 stall d2", 32'(dataOut2), 32'd20);
        end
        out_ready = 1'b1;
        tick();
        waitValid("t2 p3 valid");
        waitDone("t2 done");
        checkOutput("t2 sum1", 32'(sum1), 32'd6);
        checkOutput("t2 sum2", 32'(sum2), 32'd60);
        tick();
        checkOutput("t2 handshakes", 32'(hsCount - hsBase), 32'd3);
        for (int i = 0; i < 3; i++) begin
            checkOutput("t2 order d1", 32'(logD1[hsBase + i]), 32'(i + 1));
            checkOutput("t2 order d2", 32'(logD2[hsBase + i]), 32'((i + 1) * 10));
        end

        // Address wrap-around
        mem[8'hFF] = 16'd7; mem[8'h00] = 16'd5; mem[8'hFE] = 16'd100;
        hsBase = hsCount; doneBase = doneCount;
        applyStimulus(8'hFF, 8'hFE, 9'd3);
        waitDone("t3 done");
        checkOutput("t3 sum1", 32'(sum1), 32'd81);
        checkOutput("t3 sum2", 32'(sum2), 32'd112);
        tick();
        checkOutput("t3 a1 0", 32'(logA1[hsBase]), 32'hFF);
        checkOutput("t3 a1 1", 32'(logA1[hsBase + 1]), 32'h00);
        checkOutput("t3 a1 2", 32'(logA1[hsBase + 2]), 32'h01);
        checkOutput("t3 a2 0", 32'(logA2[hsBase]), 32'hFE);
        checkOutput("t3 a2 1", 32'(logA2[hsBase + 1]), 32'hFF);
        checkOutput("t3 a2 2", 32'(logA2[hsBase + 2]), 32'h00);
        checkOutput("t3 done count", 32'(doneCount - doneBase), 32'd1);

        // Zero-length transfer
        busyBase = busyCount; validBase = validCount;
        applyStimulus(8'd0, 8'd0, 9'd0);
        checkOutput("t4 done", 32'(done), 32'd1);
        checkOutput("t4 busy", 32'(busy), 32'd0);
        checkOutput("t4 sum1", 32'(sum1), 32'd0);
        checkOutput("t4 sum2", 32'(sum2), 32'd0);
        tick();
        checkOutput("t4 done low", 32'(done), 32'd0);
        checkOutput("t4 busy seen", 32'(busyCount - busyBase), 32'd0);
        checkOutput("t4 valid seen", 32'(validCount - validBase), 32'd0);

        // Reset in WAIT of the second pair, then a fresh run
        applyStimulus(8'd30, 8'd40, 9'd4);
        waitValid("t5 p1 valid");
        tick();
        tick();
        checkOutput("t5 pre-reset busy", 32'(busy), 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checkOutput("t5 rst busy", 32'(busy), 32'd0);
        checkOutput("t5 rst valid", 32'(out_valid), 32'd0);
        checkOutput("t5 rst done", 32'(done), 32'd0);
        checkOutput("t5 rst addr1", 32'(addr1), 32'd0);
        checkOutput("t5 rst addr2", 32'(addr2), 32'd0);
        checkOutput("t5 rst d1", 32'(dataOut1), 32'd0);
        checkOutput("t5 rst d2", 32'(dataOut2), 32'd0);
        checkOutput("t5 rst sum1", 32'(sum1), 32'd0);
        checkOutput("t5 rst sum2", 32'(sum2), 32'd0);
        e1 = '{16'd1, 16'd2, 16'd3, 16'd4};
        e2 = '{16'd10, 16'd20, 16'd30, 16'd40};
        for (int i = 0; i < 4; i++) begin
            mem[50 + i] = e1[i];
            mem[60 + i] = e2[i];
        end
        hsBase = hsCount;
        applyStimulus(8'd50, 8'd60, 9'd4);
        for (int i = 0; i < 4; i++) begin
            waitValid("t5 valid");
            checkOutput("t5 d1", 32'(dataOut1), 32'(e1[i]));
            checkOutput("t5 d2", 32'(dataOut2), 32'(e2[i]));
            tick();
        end
        waitDone("t5 done");
        checkOutput("t5 sum1", 32'(sum1), 32'd10);
        checkOutput("t5 sum2", 32'(sum2), 32'd100);
        tick();
        checkOutput("t5 handshakes", 32'(hsCount - hsBase), 32'd4);
        checkOutput("t5 first a1", 32'(logA1[hsBase]), 32'd50);
        checkOutput("t5 last a2", 32'(logA2[hsBase + 3]), 32'd63);

        // start held high through the transfer and DONE
        hsBase = hsCount; doneBase = doneCount;
        applyStimulus(8'd10, 8'd20, 9'd2);
        start = 1'b1;
        base_addr1 = 8'd50; base_addr2 = 8'd60; len = 9'd1;
        tick(); tick();
        tick();
        checkOutput("t6 c4 addr1", 32'(addr1), 32'd11);
        checkOutput("t6 c4 addr2", 32'(addr2), 32'd21);
        tick(); tick(); tick();
        checkOutput("t6 c7 done", 32'(done), 32'd1);
        checkOutput("t6 sum1", 32'(sum1), 32'd3);
        checkOutput("t6 sum2", 32'(sum2), 32'd30);
        tick();
        checkOutput("t6 c8 busy", 32'(busy), 32'd0);
        checkOutput("t6 c8 done", 32'(done), 32'd0);
        checkOutput("t6 done count", 32'(doneCount - doneBase), 32'd1);
        tick();
        start = 1'b0;
        checkOutput("t6 c9 busy", 32'(busy), 32'd1);
        checkOutput("t6 c9 addr1", 32'(addr1), 32'd50);
        checkOutput("t6 c9 addr2", 32'(addr2), 32'd60);
        waitDone("t6 second done");
        checkOutput("t6 second sum1", 32'(sum1), 32'd1);
        checkOutput("t6 second sum2", 32'(sum2), 32'd10);
        tick();
        checkOutput("t6 handshakes", 32'(hsCount - hsBase), 32'd3);
        checkOutput("we never high", 32'(weCount), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule

// File: doc/exemem_reader.md
Name: exemem_reader

Overview:
Read-side counterpart to the dual-port exemem write FSM. On a start pulse it reads a block of consecutive words from both ports of the dual-port block RAM at the same time, one address pair per transfer. Each word pair is presented on a valid/ready output stream, and a running checksum is kept per port. Sits between the dual-port memory and any consumer that checks or forwards memory contents, such as a display or a verification harness.

Parameters:
DATA_WIDTH, 16, memory word width
ADDR_WIDTH, 8, memory address width
LEN_WIDTH, ADDR_WIDTH+1, width of transfer length (allows a full 2^ADDR_WIDTH word read)

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-low reset (reset==0 at posedge resets the block)
start  in  1  request a block read; sampled only in IDLE
base_addr1  in  ADDR_WIDTH  port-1 start address, latched on accepted start
base_addr2  in  ADDR_WIDTH  port-2 start address, latched on accepted start
len  in  LEN_WIDTH  number of word pairs, latched on accepted start
addr1  out  ADDR_WIDTH  memory port-1 address
addr2  out  ADDR_WIDTH  memory port-2 address
we1  out  1  memory port-1 write enable, constant 0
we2  out  1  memory port-2 write enable, constant 0
memOut1  in  DATA_WIDTH  memory port-1 read data (1-cycle synchronous latency)
memOut2  in  DATA_WIDTH  memory port-2 read data
dataOut1  out  DATA_WIDTH  captured port-1 word
dataOut2  out  DATA_WIDTH  captured port-2 word
out_valid  out  1  dataOut1/dataOut2 hold a valid pair
out_ready  in  1  consumer accepts the pair
sum1  out  DATA_WIDTH  running checksum of port-1 words
sum2  out  DATA_WIDTH  running checksum of port-2 words
busy  out  1  transfer in progress
done  out  1  one-cycle pulse when a transfer ends

Behaviour:
- Reset (reset==0 at posedge) applies in any state, including mid-transfer:
  - state goes to IDLE.
  - addr1, addr2, dataOut1, dataOut2, sum1, sum2, the internal counter and latched length all go to 0.
  - out_valid, busy and done go to 0.
- States: IDLE, ADDR, WAIT, OUT, DONE.
- IDLE:
  - start==1 latches base_addr1, base_addr2 and len, and clears sum1/sum2 and the counter.
  - If len==0, next state is DONE; otherwise next state is ADDR.
  - start is ignored in every other state.
- ADDR: addr1/addr2 are driven with the current pair addresses (registered outputs, stable for the whole state). Next state is WAIT.
- WAIT: memOut1/memOut2 are valid. At the closing edge:
  - dataOut1<=memOut1 and dataOut2<=memOut2.
  - sum1<=sum1+memOut1 and sum2<=sum2+memOut2, both wrapping modulo 2^DATA_WIDTH.
  - Next state is OUT.
- OUT:
  - out_valid=1; dataOut1/dataOut2 stay stable until the handshake.
  - Handshake (out_valid && out_ready at posedge): counter increments, and both addresses increment modulo 2^ADDR_WIDTH (0xFF wraps to 0x00).
  - After the handshake, next state is DONE if counter+1==len, else ADDR.
  - With out_ready==0 the block holds OUT indefinitely.
- DONE: done=1 for exactly one cycle, then IDLE.
- busy=1 in ADDR, WAIT and OUT; busy=0 in IDLE and DONE.
- dataOut1/dataOut2 and sum1/sum2 keep their last values after DONE until the next accepted start or reset.
- Latency:
  - start sampled at edge E0, giving ADDR in cycle 1, WAIT in cycle 2 and OUT (out_valid=1) in cycle 3.
  - With out_ready held at 1, throughput is one pair every 3 cycles.
- we1 and we2 are tied to 0; the block never writes memory.

Decomposition:
- Shared package (exemem_pkg): DATA_WIDTH/ADDR_WIDTH defaults and the state encoding constants (IDLE=0, ADDR=1, WAIT=2, OUT=3, DONE=4, 3-bit). The exemem writer FSM and the benches use the same package.
- Single module with no sub-module. The checksum adders and the address counters are inline.

Test Plan:
- Preload mem[1]=16'd69 and mem[3]=16'd21; start with base1=1, base2=3, len=1, out_ready=1 -> out_valid in cycle 3 with dataOut1=0x0045 and dataOut2=0x0015; done one cycle after the handshake; sum1=69, sum2=21.
- Preload mem[10..12]={1,2,3} (port 1) and mem[20..22]={10,20,30} (port 2); len=3; out_ready low for 4 cycles on the second pair -> out_valid and data held stable; pairs arrive in order (1,10), (2,20), (3,30); sum1=6, sum2=60; exactly 3 handshakes.
- base1=8'hFF, base2=8'hFE, len=3 -> port-1 addresses FF, 00, 01 and port-2 addresses FE, FF, 00 (wrap-around); done asserted once.
- len=0 -> busy never asserted, out_valid never asserted, done pulses the cycle after start, sums=0.
- Reset asserted low in WAIT of the second pair of a len=4 transfer -> next cycle IDLE with all outputs 0. A following start runs the whole transfer from the new base addresses.
- start pulsed again while busy, and held high through DONE -> mid-transfer start is ignored and the transfer completes normally. Holding start through DONE starts a new transfer only from IDLE; we1/we2 stay 0 throughout.
